microwave_timer: RTL and testbench

- Cooking countdown timer for the microwave controller; sits directly upstream of the magnetron control stage and produces its timer_done input.
- Accepts keypad digits into a 4-digit BCD MM:SS register.
- Counts down once per second while the magnetron is on, and asserts timer_done on reaching 00:00.

---
 rtl/microwave_timer.sv | 227 ++++++++++++++++++++++
 tb/tb_microwave_timer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer.sv
// ---------------------------------------------------------------------------
// microwave_timer
//
// Cooking countdown timer for the microwave controller. Keypad digits shift
// into a 4-digit BCD MM:SS register. While the magnetron is on, the register
// counts down once per TICK_DIV clock cycles. timer_done is raised when it
// reaches 00:00, and that signal feeds the magnetron stage reset path.
//
// Parameters:
//   TICK_DIV   clock cycles per one-second decrement (>= 2)
//
// Ports:
//   clock       in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   clearn      in   active-low synchronous clear (keypad CLEAR key)
//   key_valid   in   one-cycle strobe qualifying key_code
//   key_code    in   [3:0] digit 0..9; codes 10..15 are ignored
//   mag_on      in   magnetron latch state; high enables counting
//   timer_done  out  cooking time expired (registered)
//   running     out  high while counting (registered)
//   time_bcd    out  [15:0] {min_tens, min_ones, sec_tens, sec_ones}
//   beep        out  completion beeper (only with TIMER_BEEP_EN)
//
// Optional feature: define TIMER_BEEP_EN to add the beep output. When the
// timer enters DONE, beep toggles every TICK_DIV/2 cycles for 3*TICK_DIV
// cycles.
// ---------------------------------------------------------------------------
module microwave_timer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        clearn,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        mag_on,
    output logic        timer_done,
    output logic        running,
`ifdef TIMER_BEEP_EN
    output logic        beep,
`endif
    output logic [15:0] time_bcd
);

    localparam logic [1:0] ST_ENTRY = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    logic [1:0]    state_q,   state_d;
    logic [15:0]   time_q,    time_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic          done_q,    done_d;
    logic          running_q, running_d;

    logic          key_ok;
    logic [15:0]   time_shift;
    logic [15:0]   time_dec;

    // Decrement MM:SS by one second. A zero digit wraps to 9, or to 5 for
    // sec_tens, and borrows from the next digit up. The seconds are not
    // range-checked, so 0:90 simply counts down through 89.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] so, st, mo, mt;
        so = t[3:0];
        st = t[7:4];
        mo = t[11:8];
        mt = t[15:12];
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign key_ok     = key_valid && (key_code <= 4'd9) && !mag_on;
    assign time_shift = {time_q[11:0], key_code};
    assign time_dec   = bcd_dec(time_q);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        if (!clearn) begin
            state_d = ST_ENTRY;
            time_d  = 16'h0000;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_ENTRY, ST_PAUSE: begin
                    if (mag_on) begin
                        // A zero setting started from entry expires at once.
                        state_d = (time_q != 16'h0000) ? ST_COUNT : ST_DONE;
                    end else if (key_ok) begin
                        time_d = time_shift;
                    end
                end
                ST_COUNT: begin
                    if (!mag_on) begin
                        // Freeze the prescaler so that resuming keeps the
                        // sub-second phase.
                        state_d = ST_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        time_d  = time_dec;
                        if (time_dec == 16'h0000) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: begin // ST_DONE
                    if (key_ok) begin
                        time_d  = time_shift;
                        state_d = ST_ENTRY;
                    end
                end
            endcase
            // In DONE the prescaler is held at zero, so the next count starts
            // a full second before its first decrement.
            if (state_d == ST_DONE) begin
                presc_d = '0;
            end
        end
        done_d    = (state_d == ST_DONE);
        running_d = (state_d == ST_COUNT);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_ENTRY;
            time_q    <= 16'h0000;
            presc_q   <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign timer_done = done_q;
    assign running    = running_q;
    assign time_bcd   = time_q;

`ifdef TIMER_BEEP_EN
    localparam int HALF = (TICK_DIV / 2 > 1) ? TICK_DIV / 2 : 1;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CW   = $clog2(3 * TICK_DIV);

    localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
    localparam logic [CW-1:0] BEEP_LAST = CW'(3 * TICK_DIV - 1);

    logic          beep_q,     beep_d;
    logic          beep_act_q, beep_act_d;
    logic [HW-1:0] half_q,     half_d;
    logic [CW-1:0] bcnt_q,     bcnt_d;

    always_comb begin
        beep_d     = beep_q;
        beep_act_d = beep_act_q;
        half_d     = half_q;
        bcnt_d     = bcnt_q;
        if (!clearn || state_d != ST_DONE) begin
            // A clear or a key press leaves DONE, which silences the beeper.
            beep_d     = 1'b0;
            beep_act_d = 1'b0;
            half_d     = '0;
            bcnt_d     = '0;
        end else if (state_q != ST_DONE) begin
            beep_d     = 1'b0;
            beep_act_d = 1'b1;
            half_d     = '0;
            bcnt_d     = '0;
        end else if (beep_act_q) begin
            if (bcnt_q == BEEP_LAST) begin
                beep_d     = 1'b0;
                beep_act_d = 1'b0;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    beep_d = ~beep_q;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            beep_q     <= 1'b0;
            beep_act_q <= 1'b0;
            half_q     <= '0;
            bcnt_q     <= '0;
        end else begin
            beep_q     <= beep_d;
            beep_act_q <= beep_act_d;
            half_q     <= half_d;
            bcnt_q     <= bcnt_d;
        end
    end

    assign beep = beep_q;
`endif

endmodule

// File: tb/tb_microwave_timer.sv
// ---------------------------------------------------------------------------
// Testbench for microwave_timer (TICK_DIV = 4).
//
// The reference model keeps the setting as integer minutes and seconds. It
// also tracks the number of cycles spent counting toward the next one-second
// tick. Inputs change on the falling edge, and outputs are sampled on the
// following falling edge.
// ---------------------------------------------------------------------------
module tb_microwave_timer;

    localparam int TD = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        clearn = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        mag_on = 1'b0;
    logic        timer_done;
    logic        running;
    logic [15:0] time_bcd;
`ifdef TIMER_BEEP_EN
    logic        beep;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_min, m_sec, m_phase;
    bit m_done, m_run;

    microwave_timer #(.TICK_DIV(TD)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .clearn     (clearn),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .mag_on     (mag_on),
        .timer_done (timer_done),
        .running    (running),
`ifdef TIMER_BEEP_EN
        .beep       (beep),
`endif
        .time_bcd   (time_bcd)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] enc(input int mn, input int s);
        return {4'(mn / 10), 4'(mn % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [17:0] exp_vec();
        return {m_done, m_run, enc(m_min, m_sec)};
    endfunction

    task automatic model_clear();
        m_min = 0; m_sec = 0; m_phase = 0; m_done = 0; m_run = 0;
    endtask

    task automatic model_key(input logic [3:0] kc);
        m_min = (m_min % 10) * 10 + m_sec / 10;
        m_sec = (m_sec % 10) * 10 + int'(kc);
    endtask

    task automatic model_step(input bit cl, input bit kv, input logic [3:0] kc, input bit mg);
        bit key_ok;
        key_ok = kv && (kc <= 4'd9) && !mg;
        if (!cl) begin
            model_clear();
        end else if (m_done) begin
            if (key_ok) begin
                model_key(kc);
                m_done = 0;
            end
        end else if (m_run) begin
            if (!mg) begin
                m_run = 0;
            end else begin
                m_phase++;
                if (m_phase == TD) begin
                    m_phase = 0;
                    if (m_sec > 0) m_sec--;
                    else begin m_min--; m_sec = 59; end
                    if (m_min == 0 && m_sec == 0) begin
                        m_done = 1;
                        m_run = 0;
                    end
                end
            end
        end else begin
            if (mg) begin
                if (m_min == 0 && m_sec == 0) begin
                    m_done = 1;
                    m_phase = 0;
                end else begin
                    m_run = 1;
                end
            end else if (key_ok) begin
                model_key(kc);
            end
        end
    endtask

    // One clock: drive inputs, update the model at the edge, then settle.
    task automatic step(input bit cl, input bit kv, input logic [3:0] kc, input bit mg);
        clearn = cl; key_valid = kv; key_code = kc; mag_on = mg;
        @(posedge clock);
        model_step(cl, kv, kc, mg);
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        model_clear();
        checks++;
        if ({timer_done, running, time_bcd} !== 18'h0) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", {timer_done, running, time_bcd}, 18'h0);
        end
        resetn = 1'b1;
        step(1, 0, 0, 0);
        checks++;
        if ({timer_done, running, time_bcd} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle: got %h required %h", {timer_done, running, time_bcd}, exp_vec());
        end
        $display("test_reset: outputs=%h", {timer_done, running, time_bcd});
    endtask

    task automatic test_entry();
        logic [3:0] keys [3] = '{4'd1, 4'd3, 4'd0};
        for (int i = 0; i < 3; i++) begin
            step(1, 1, keys[i], 0);
            checks++;
            if ({timer_done, running, time_bcd} !== exp_vec()) begin
                errors++;
                $display("FAIL entry_key%0d: got %h required %h", i, {timer_done, running, time_bcd}, exp_vec());
            end
        end
        checks++;
        if (time_bcd !== 16'h0130) begin
            errors++;
            $display("FAIL entry_0130: got %h required 0130", time_bcd);
        end
        $display("test_entry: time_bcd=%h", time_bcd);
    endtask

    task automatic test_countdown();
        step(1, 0, 0, 1);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL countdown_running: got %b required 1", running);
        end
        for (int i = 0; i < 400 && !m_done; i++) begin
            step(1, 0, 0, 1);
            checks++;
            if ({timer_done, running, time_bcd} !== exp_vec()) begin
                errors++;
                $display("FAIL countdown_cycle%0d: got %h required %h", i, {timer_done, running, time_bcd}, exp_vec());
            end
        end
        checks++;
        if ({timer_done, running, time_bcd} !== 18'h20000) begin
            errors++;
            $display("FAIL countdown_done: got %h required 20000", {timer_done, running, time_bcd});
        end
        $display("test_countdown: done=%b time_bcd=%h", timer_done, time_bcd);
    endtask

    task automatic test_pause_resume();
        logic [3:0] keys [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        bit mags [12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, keys[i], 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, mags[i]);
            checks++;
            if ({timer_done, running, time_bcd} !== exp_vec()) begin
                errors++;
                $display("FAIL pause_cycle%0d: got %h required %h", i, {timer_done, running, time_bcd}, exp_vec());
            end
            if (i == 4) begin
                checks++;
                if (time_bcd !== 16'h0959) begin
                    errors++;
                    $display("FAIL pause_first_tick: got %h required 0959", time_bcd);
                end
            end
        end
        step(1, 0, 0, 1);
        checks++;
        if (time_bcd !== 16'h0958) begin
            errors++;
            $display("FAIL pause_resume_tick: got %h required 0958", time_bcd);
        end
        $display("test_pause_resume: time_bcd=%h", time_bcd);
    endtask

    task automatic test_zero_start();
        step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        checks++;
        if ({timer_done, running, time_bcd} !== 18'h20000) begin
            errors++;
            $display("FAIL zero_start_done: got %h required 20000", {timer_done, running, time_bcd});
        end
        step(1, 1, 4'd5, 0);
        checks++;
        if ({timer_done, running, time_bcd} !== 18'h00005) begin
            errors++;
            $display("FAIL zero_start_key: got %h required 00005", {timer_done, running, time_bcd});
        end
        $display("test_zero_start: done=%b time_bcd=%h", timer_done, time_bcd);
    endtask

    task automatic test_ignored_keys();
        step(0, 0, 0, 0);
        step(1, 1, 4'd4, 0);
        step(1, 1, 4'd2, 0);
        step(1, 1, 4'd12, 0);
        checks++;
        if (time_bcd !== 16'h0042) begin
            errors++;
            $display("FAIL ignored_code12: got %h required 0042", time_bcd);
        end
        step(1, 1, 4'd7, 1);
        checks++;
        if ({timer_done, running, time_bcd} !== exp_vec()) begin
            errors++;
            $display("FAIL ignored_mag_key: got %h required %h", {timer_done, running, time_bcd}, exp_vec());
        end
        $display("test_ignored_keys: time_bcd=%h", time_bcd);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 1);
            checks++;
            if ({timer_done, running, time_bcd} !== 18'h0) begin
                errors++;
                $display("FAIL clear_hold%0d: got %h required 00000", i, {timer_done, running, time_bcd});
            end
        end
        $display("test_clear: outputs=%h", {timer_done, running, time_bcd});
    endtask

    task automatic test_random();
        bit mg = 0;
        bit cl, kv;
        logic [3:0] kc;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) mg = !mg;
            cl = ($urandom_range(0, 59) != 0);
            kv = ($urandom_range(0, 3) == 0);
            kc = 4'($urandom_range(0, 15));
            step(cl, kv, kc, mg);
            checks++;
            if ({timer_done, running, time_bcd} !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h required %h", i, {timer_done, running, time_bcd}, exp_vec());
            end
        end
        $display("test_random: final outputs=%h", {timer_done, running, time_bcd});
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 0);
        step(1, 1, 4'd9, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        #2;
        resetn = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({timer_done, running, time_bcd} !== 18'h0) begin
            errors++;
            $display("FAIL async_reset: got %h required 00000", {timer_done, running, time_bcd});
        end
        @(negedge clock);
        resetn = 1'b1;
        step(1, 0, 0, 0);
        checks++;
        if ({timer_done, running, time_bcd} !== exp_vec()) begin
            errors++;
            $display("FAIL async_reset_release: got %h required %h", {timer_done, running, time_bcd}, exp_vec());
        end
        $display("test_async_reset: outputs=%h", {timer_done, running, time_bcd});
    endtask

`ifdef TIMER_BEEP_EN
    task automatic test_beep();
        int toggles = 0;
        logic prev;
        step(0, 0, 0, 0);
        step(1, 1, 4'd1, 0);
        for (int i = 0; i < 20 && !m_done; i++) step(1, 0, 0, 1);
        prev = beep;
        for (int i = 0; i < 3 * TD + 4; i++) begin
            step(1, 0, 0, 0);
            if (beep !== prev) toggles++;
            prev = beep;
        end
        checks++;
        if (toggles != 6 || beep !== 1'b0) begin
            errors++;
            $display("FAIL beep_toggles: got %0d toggles beep=%b required 6 toggles beep=0", toggles, beep);
        end
        $display("test_beep: toggles=%0d", toggles);
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_entry();
        test_countdown();
        test_pause_resume();
        test_zero_start();
        test_ignored_keys();
        test_clear();
        test_random();
        test_async_reset();
`ifdef TIMER_BEEP_EN
        test_beep();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
